wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Owns the single register-file write port after the MEM/WB register.
//  Merges in-order writebacks from the W stage with out-of-order completions from the MCycle unit (mul/div).
//  The M/W stage is never stalled. MCycle results are buffered in a small FIFO and drained into idle W slots.
//  Exports pending-rd hit flags to the hazard unit and a bubble request on starvation.
// PARAMETERS
//  XLEN          32  data width
//  DEPTH         4   MCycle result FIFO entries; power of 2, >=2
//  STARVE_LIMIT  8   consecutive non-draining cycles with FIFO non-empty before BubbleReq
// PORTS
//  CLK        in   1     clock, rising edge
//  RESET      in   1     synchronous reset, active-high
//  RegWriteW  in   1     W-stage write enable
//  rdW        in   5     W-stage destination
//  ResultW    in   XLEN  W-stage writeback data (already muxed ReadDataW/ComputeResultW)
//  McValid    in   1     MCycle result valid; held until McReady
//  McRd       in   5     MCycle destination
//  McResult   in   XLEN  MCycle result data
//  McReady    out  1     FIFO can accept (push = McValid & McReady)
//  QueryRs1   in   5     decode-stage rs1
//  QueryRs2   in   5     decode-stage rs2
//  QueryRd    in   5     decode-stage rd (WAW check)
//  PendHit    out  3     {Rd,Rs2,Rs1} match a pending MCycle destination
//  RFWE       out  1     register-file write enable
//  RFWA       out  5     register-file write address
//  RFWD       out  XLEN  register-file write data
//  BubbleReq  out  1     request upstream to inject one W-bound bubble
//  PendCount  out  log2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  - Reset: FIFO empty, starve counter 0.
//    While RESET=1: RFWE=0, McReady=0, PendHit=0, BubbleReq=0, PendCount=0, RFWA=0, RFWD=0.
//  - W slot busy = RegWriteW & (rdW!=0). Fixed priority goes to W.
//    W busy: RFWE=1, RFWA=rdW, RFWD=ResultW; no pop.
//    W idle & FIFO non-empty: pop head; RFWE=1, RFWA/RFWD = head rd/data.
//    Otherwise: RFWE=0, RFWA=0, RFWD=0.
//  - RF port outputs are combinational from current inputs and FIFO head. Writes land on the same CLK edge.
//  - McReady = !full (no same-cycle pop credit). A push is visible at the head from the next cycle.
//    Minimum MCycle-to-RF latency is 1 cycle.
//  - McRd==0: the handshake completes and the result is discarded (not enqueued).
//  - Push and pop in the same cycle: both occur, PendCount unchanged, pointers wrap modulo DEPTH.
//  - Full with McValid=1: McReady=0. MCycle holds its result and nothing is lost.
//  - PendHit[i] = (Query_i!=0) and Query_i equals any valid FIFO rd, or equals McRd while McValid.
//    The path is combinational. The hazard unit stalls decode on any bit.
//  - Starve counter: +1 each cycle with FIFO non-empty and no pop, saturating at STARVE_LIMIT.
//    Cleared on pop or when empty.
//  - BubbleReq is registered. It is set the cycle after the counter reaches STARVE_LIMIT.
//    It is held until the first pop, then cleared on the next edge.
//  - Ordering: FIFO drains in push order. W and FIFO never target the same rd (PendHit WAW guarantee).
//    No ordering check is performed here.
//  - RESET mid-operation: pending entries are dropped and the MCycle unit is reset by the same RESET.
// STRUCTURE
//  - Shared package mach_v_pkg: XLEN, REG_ADDR_W=5, ZERO_REG constant.
//  - Sub-module wb_pend_fifo: DEPTH-entry {rd,data} FIFO with per-entry valid bits.
//    Provides combinational 3-way rd CAM match, full/empty, and count.
//  - Top level holds the priority mux, the McRd==0 discard and the starvation counter/BubbleReq FSM.
//    Starvation FSM states: IDLE, WAIT, REQ.
// TESTING
//  1 W only: RegWriteW=1, rdW=5, ResultW=0x11 with FIFO empty -> RFWE=1, RFWA=5, RFWD=0x11 the same cycle.
//  2 W busy, then idle: McValid with McRd=7, data 0xAB while W busy; W idles next cycle
//    -> RF writes 7/0xAB that cycle and PendCount returns to 0.
//  3 Fill FIFO: 4 pushes (rd 1..4) with W always busy -> McReady=0 after the 4th, 5th result held.
//    After 8 stalled cycles, BubbleReq=1. On W idle: head rd1 popped and McReady=1 again.
//  4 Simultaneous: FIFO count 2, W idle, push at the same time -> one pop (oldest), one push, PendCount stays 2.
//  5 Hazard query: FIFO holds rd 9, QueryRs2=9, QueryRd=0 -> PendHit=3'b010. McRd=0 push -> discarded, count unchanged.
//  6 Reset mid-drain: RESET=1 with 3 entries -> all outputs 0, and PendCount=0 after the edge.

Source files
------------

// File: rtl/mach_v_pkg.sv
// Shared core constants for the writeback path: register-file geometry and
// the starvation FSM state encoding.
package mach_v_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REQ
    } starve_state_e;
endpackage

// File: rtl/wb_pend_fifo.sv
// Pending MCycle result FIFO: {rd,data} entries with per-entry valid bits and
// a 3-way combinational rd match used for hazard detection.
module wb_pend_fifo
    import mach_v_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       push,
    input  logic [REG_ADDR_W-1:0]      push_rd,
    input  logic [XLEN-1:0]            push_data,
    input  logic                       pop,
    output logic [REG_ADDR_W-1:0]      head_rd,
    output logic [XLEN-1:0]            head_data,
    output logic                       full,
    output logic                       empty,
    output logic [CW-1:0]              count,
    input  logic [2:0][REG_ADDR_W-1:0] query,
    output logic [2:0]                 hit
);
    logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_mem;
    logic [DEPTH-1:0][XLEN-1:0]       data_mem;
    logic [DEPTH-1:0]                 vld;
    logic [AW-1:0]                    wptr, rptr;
    logic [CW-1:0]                    cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            vld  <= '0;
        end else begin
            if (pop) begin
                vld[rptr] <= 1'b0;
                rptr      <= rptr + AW'(1);
            end
            if (push) begin
                rd_mem[wptr]   <= push_rd;
                data_mem[wptr] <= push_data;
                vld[wptr]      <= 1'b1;
                wptr           <= wptr + AW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign head_rd   = rd_mem[rptr];
    assign head_data = data_mem[rptr];
    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;

    always_comb begin
        hit = '0;
        for (int q = 0; q < 3; q++)
            for (int e = 0; e < DEPTH; e++)
                if (vld[e] && (rd_mem[e] == query[q]))
                    hit[q] = 1'b1;
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: W stage has fixed priority, buffered MCycle
// results drain into idle W slots, with pending-rd hazard flags and starvation bubble request.
module wb_port_arbiter
    import mach_v_pkg::*;
#(
    parameter  int XLEN         = 32,
    parameter  int DEPTH        = 4,
    parameter  int STARVE_LIMIT = 8,
    localparam int CW           = $clog2(DEPTH) + 1,
    localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] rdW,
    input  logic [XLEN-1:0]       ResultW,
    input  logic                  McValid,
    input  logic [REG_ADDR_W-1:0] McRd,
    input  logic [XLEN-1:0]       McResult,
    output logic                  McReady,
    input  logic [REG_ADDR_W-1:0] QueryRs1,
    input  logic [REG_ADDR_W-1:0] QueryRs2,
    input  logic [REG_ADDR_W-1:0] QueryRd,
    output logic [2:0]            PendHit,
    output logic                  RFWE,
    output logic [REG_ADDR_W-1:0] RFWA,
    output logic [XLEN-1:0]       RFWD,
    output logic                  BubbleReq,
    output logic [CW-1:0]         PendCount
);
    logic                       w_busy, push, pop;
    logic                       full, empty;
    logic [REG_ADDR_W-1:0]      head_rd;
    logic [XLEN-1:0]            head_data;
    logic [CW-1:0]              fifo_cnt;
    logic [2:0][REG_ADDR_W-1:0] query;
    logic [2:0]                 fifo_hit;
    logic [SW-1:0]              starve_cnt;
    starve_state_e              state, state_nxt;

    assign w_busy = RegWriteW && (rdW != ZERO_REG);
    // Writes to x0 still complete the handshake but are never enqueued.
    assign push   = !RESET && McValid && !full && (McRd != ZERO_REG);
    assign pop    = !RESET && !w_busy && !empty;
    assign query  = {QueryRd, QueryRs2, QueryRs1};

    wb_pend_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (push),
        .push_rd   (McRd),
        .push_data (McResult),
        .pop       (pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .count     (fifo_cnt),
        .query     (query),
        .hit       (fifo_hit)
    );

    always_comb begin
        RFWE = 1'b0;
        RFWA = '0;
        RFWD = '0;
        if (RESET) begin
            RFWE = 1'b0;
        end else if (w_busy) begin
            RFWE = 1'b1;
            RFWA = rdW;
            RFWD = ResultW;
        end else if (!empty) begin
            RFWE = 1'b1;
            RFWA = head_rd;
            RFWD = head_data;
        end
    end

    // An in-flight MCycle result is as much a hazard as a queued one.
    always_comb begin
        PendHit = '0;
        for (int i = 0; i < 3; i++)
            PendHit[i] = !RESET && (query[i] != ZERO_REG) &&
                         (fifo_hit[i] || (McValid && (McRd == query[i])));
    end

    assign McReady   = !RESET && !full;
    assign PendCount = RESET ? '0 : fifo_cnt;
    assign BubbleReq = !RESET && (state == ST_REQ);

    always_ff @(posedge CLK) begin
        if (RESET || empty || pop)
            starve_cnt <= '0;
        else if (starve_cnt != SW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + SW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_REQ: begin
                if (pop) state_nxt = ST_IDLE;
            end
            default: begin
                if (!pop && (starve_cnt == SW'(STARVE_LIMIT)))
                    state_nxt = ST_REQ;
                else if (!empty && !pop)
                    state_nxt = ST_WAIT;
                else
                    state_nxt = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed-vector bench for wb_port_arbiter: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_wb_port_arbiter;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        RegWriteW;
    logic [4:0]  rdW;
    logic [31:0] ResultW;
    logic        McValid;
    logic [4:0]  McRd;
    logic [31:0] McResult;
    logic        McReady;
    logic [4:0]  QueryRs1, QueryRs2, QueryRd;
    logic [2:0]  PendHit;
    logic        RFWE;
    logic [4:0]  RFWA;
    logic [31:0] RFWD;
    logic        BubbleReq;
    logic [2:0]  PendCount;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 CLK = ~CLK;

    wb_port_arbiter #(.XLEN(32), .DEPTH(4), .STARVE_LIMIT(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .RegWriteW(RegWriteW), .rdW(rdW), .ResultW(ResultW),
        .McValid(McValid), .McRd(McRd), .McResult(McResult), .McReady(McReady),
        .QueryRs1(QueryRs1), .QueryRs2(QueryRs2), .QueryRd(QueryRd), .PendHit(PendHit),
        .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD),
        .BubbleReq(BubbleReq), .PendCount(PendCount)
    );

    task automatic idle_in();
        RegWriteW = 0; rdW = 0; ResultW = 0;
        McValid = 0; McRd = 0; McResult = 0;
        QueryRs1 = 0; QueryRs2 = 0; QueryRd = 0;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RESET = 1; idle_in();
        RegWriteW = 1; rdW = 5; ResultW = 32'h55; McValid = 1; McRd = 3; QueryRs1 = 3;
        #1;
        vec_cnt++; if (RFWE !== 1'b0)      begin err_cnt++; $display("FAIL reset_rfwe got %0h exp 0", RFWE); end
        vec_cnt++; if (RFWA !== 5'd0)      begin err_cnt++; $display("FAIL reset_rfwa got %0h exp 0", RFWA); end
        vec_cnt++; if (RFWD !== 32'd0)     begin err_cnt++; $display("FAIL reset_rfwd got %0h exp 0", RFWD); end
        vec_cnt++; if (McReady !== 1'b0)   begin err_cnt++; $display("FAIL reset_mcready got %0h exp 0", McReady); end
        vec_cnt++; if (PendHit !== 3'b000) begin err_cnt++; $display("FAIL reset_pendhit got %0b exp 000", PendHit); end
        vec_cnt++; if (BubbleReq !== 1'b0) begin err_cnt++; $display("FAIL reset_bubble got %0h exp 0", BubbleReq); end
        vec_cnt++; if (PendCount !== 3'd0) begin err_cnt++; $display("FAIL reset_count got %0d exp 0", PendCount); end
        tick(); tick();
        RESET = 0; idle_in(); #1;
        vec_cnt++; if (McReady !== 1'b1)   begin err_cnt++; $display("FAIL post_reset_mcready got %0h exp 1", McReady); end
        vec_cnt++; if (RFWE !== 1'b0)      begin err_cnt++; $display("FAIL post_reset_rfwe got %0h exp 0", RFWE); end
        tick();
    endtask

    task automatic test_w_only();
        RegWriteW = 1; rdW = 5; ResultW = 32'h11; #1;
        vec_cnt++; if (RFWE !== 1'b1)      begin err_cnt++; $display("FAIL w_only_rfwe got %0h exp 1", RFWE); end
        vec_cnt++; if (RFWA !== 5'd5)      begin err_cnt++; $display("FAIL w_only_rfwa got %0d exp 5", RFWA); end
        vec_cnt++; if (RFWD !== 32'h11)    begin err_cnt++; $display("FAIL w_only_rfwd got %0h exp 11", RFWD); end
        RegWriteW = 1; rdW = 0; ResultW = 32'h22; #1;
        vec_cnt++; if (RFWE !== 1'b0)      begin err_cnt++; $display("FAIL w_x0_rfwe got %0h exp 0", RFWE); end
        tick(); idle_in();
    endtask

    task automatic test_w_then_idle();
        RegWriteW = 1; rdW = 3; ResultW = 32'h33;
        McValid = 1; McRd = 7; McResult = 32'hAB; QueryRs1 = 7; #1;
        vec_cnt++; if (McReady !== 1'b1)   begin err_cnt++; $display("FAIL wti_mcready got %0h exp 1", McReady); end
        vec_cnt++; if (RFWA !== 5'd3)      begin err_cnt++; $display("FAIL wti_rfwa_w got %0d exp 3", RFWA); end
        vec_cnt++; if (PendHit !== 3'b001) begin err_cnt++; $display("FAIL wti_hit_inflight got %0b exp 001", PendHit); end
        tick();
        RegWriteW = 0; McValid = 0; #1;
        vec_cnt++; if (PendCount !== 3'd1) begin err_cnt++; $display("FAIL wti_count1 got %0d exp 1", PendCount); end
        vec_cnt++; if (PendHit !== 3'b001) begin err_cnt++; $display("FAIL wti_hit_fifo got %0b exp 001", PendHit); end
        vec_cnt++; if (RFWE !== 1'b1 || RFWA !== 5'd7 || RFWD !== 32'hAB)
            begin err_cnt++; $display("FAIL wti_drain got %0h/%0d/%0h exp 1/7/ab", RFWE, RFWA, RFWD); end
        tick();
        vec_cnt++; if (PendCount !== 3'd0) begin err_cnt++; $display("FAIL wti_count0 got %0d exp 0", PendCount); end
        vec_cnt++; if (RFWE !== 1'b0 || RFWA !== 5'd0) begin err_cnt++; $display("FAIL wti_idle got %0h/%0d exp 0/0", RFWE, RFWA); end
        idle_in();
    endtask

    task automatic test_fill();
        RegWriteW = 1; rdW = 20; ResultW = 32'hEE;
        for (int i = 1; i <= 4; i++) begin
            McValid = 1; McRd = 5'(i); McResult = 32'h100 + 32'(i); #1;
            vec_cnt++; if (McReady !== 1'b1) begin err_cnt++; $display("FAIL fill_ready%0d got %0h exp 1", i, McReady); end
            tick();
        end
        // cycle 4 relative to the first push
        McValid = 1; McRd = 5; McResult = 32'h105; #1;
        vec_cnt++; if (PendCount !== 3'd4) begin err_cnt++; $display("FAIL fill_count got %0d exp 4", PendCount); end
        vec_cnt++; if (McReady !== 1'b0)   begin err_cnt++; $display("FAIL fill_full got %0h exp 0", McReady); end
        vec_cnt++; if (RFWA !== 5'd20)     begin err_cnt++; $display("FAIL fill_wprio got %0d exp 20", RFWA); end
        repeat (4) tick();
        vec_cnt++; if (BubbleReq !== 1'b0) begin err_cnt++; $display("FAIL fill_bubble_early got %0h exp 0", BubbleReq); end
        tick(); tick();
        vec_cnt++; if (BubbleReq !== 1'b1) begin err_cnt++; $display("FAIL fill_bubble got %0h exp 1", BubbleReq); end
        vec_cnt++; if (PendCount !== 3'd4) begin err_cnt++; $display("FAIL fill_held got %0d exp 4", PendCount); end
        RegWriteW = 0; #1;
        vec_cnt++; if (RFWE !== 1'b1 || RFWA !== 5'd1 || RFWD !== 32'h101)
            begin err_cnt++; $display("FAIL fill_pop1 got %0h/%0d/%0h exp 1/1/101", RFWE, RFWA, RFWD); end
        vec_cnt++; if (McReady !== 1'b0)   begin err_cnt++; $display("FAIL fill_nocredit got %0h exp 0", McReady); end
        tick();
        vec_cnt++; if (PendCount !== 3'd3) begin err_cnt++; $display("FAIL fill_count3 got %0d exp 3", PendCount); end
        vec_cnt++; if (McReady !== 1'b1)   begin err_cnt++; $display("FAIL fill_ready_again got %0h exp 1", McReady); end
        vec_cnt++; if (BubbleReq !== 1'b0) begin err_cnt++; $display("FAIL fill_bubble_clr got %0h exp 0", BubbleReq); end
        vec_cnt++; if (RFWA !== 5'd2)      begin err_cnt++; $display("FAIL fill_pop2 got %0d exp 2", RFWA); end
        tick();
        McValid = 0; #1;
        vec_cnt++; if (PendCount !== 3'd3) begin err_cnt++; $display("FAIL fill_pushpop got %0d exp 3", PendCount); end
        for (int r = 3; r <= 5; r++) begin
            vec_cnt++; if (RFWA !== 5'(r) || RFWD !== 32'h100 + 32'(r))
                begin err_cnt++; $display("FAIL fill_order got %0d/%0h exp %0d/%0h", RFWA, RFWD, r, 32'h100 + 32'(r)); end
            tick();
        end
        vec_cnt++; if (PendCount !== 3'd0 || RFWE !== 1'b0)
            begin err_cnt++; $display("FAIL fill_empty got %0d/%0h exp 0/0", PendCount, RFWE); end
        idle_in();
    endtask

    task automatic test_simul();
        RegWriteW = 1; rdW = 21; ResultW = 32'h0;
        McValid = 1; McRd = 10; McResult = 32'hA0; tick();
        McRd = 11; McResult = 32'hA1; tick();
        RegWriteW = 0; McRd = 12; McResult = 32'hA2; #1;
        vec_cnt++; if (PendCount !== 3'd2) begin err_cnt++; $display("FAIL simul_pre got %0d exp 2", PendCount); end
        vec_cnt++; if (RFWA !== 5'd10 || RFWD !== 32'hA0)
            begin err_cnt++; $display("FAIL simul_oldest got %0d/%0h exp 10/a0", RFWA, RFWD); end
        vec_cnt++; if (McReady !== 1'b1)   begin err_cnt++; $display("FAIL simul_ready got %0h exp 1", McReady); end
        tick();
        McValid = 0; #1;
        vec_cnt++; if (PendCount !== 3'd2) begin err_cnt++; $display("FAIL simul_post got %0d exp 2", PendCount); end
        vec_cnt++; if (RFWA !== 5'd11 || RFWD !== 32'hA1)
            begin err_cnt++; $display("FAIL simul_next got %0d/%0h exp 11/a1", RFWA, RFWD); end
        tick();
        vec_cnt++; if (RFWA !== 5'd12 || RFWD !== 32'hA2)
            begin err_cnt++; $display("FAIL simul_last got %0d/%0h exp 12/a2", RFWA, RFWD); end
        tick();
        vec_cnt++; if (PendCount !== 3'd0) begin err_cnt++; $display("FAIL simul_empty got %0d exp 0", PendCount); end
        idle_in();
    endtask

    task automatic test_hazard();
        RegWriteW = 1; rdW = 22; ResultW = 32'h0;
        McValid = 1; McRd = 9; McResult = 32'h99; tick();
        McValid = 0; QueryRs1 = 8; QueryRs2 = 9; QueryRd = 0; #1;
        vec_cnt++; if (PendHit !== 3'b010) begin err_cnt++; $display("FAIL hz_rs2 got %0b exp 010", PendHit); end
        QueryRs1 = 9; QueryRd = 9; #1;
        vec_cnt++; if (PendHit !== 3'b111) begin err_cnt++; $display("FAIL hz_all got %0b exp 111", PendHit); end
        McValid = 1; McRd = 17; QueryRs1 = 0; QueryRs2 = 0; QueryRd = 17; #1;
        vec_cnt++; if (PendHit !== 3'b100) begin err_cnt++; $display("FAIL hz_inflight_rd got %0b exp 100", PendHit); end
        McRd = 0; McResult = 32'hDEAD; QueryRd = 0; #1;
        vec_cnt++; if (PendHit !== 3'b000) begin err_cnt++; $display("FAIL hz_zero got %0b exp 000", PendHit); end
        vec_cnt++; if (McReady !== 1'b1)   begin err_cnt++; $display("FAIL hz_x0_ready got %0h exp 1", McReady); end
        tick();
        McValid = 0; #1;
        vec_cnt++; if (PendCount !== 3'd1) begin err_cnt++; $display("FAIL hz_x0_discard got %0d exp 1", PendCount); end
        RegWriteW = 0; #1;
        vec_cnt++; if (RFWA !== 5'd9 || RFWD !== 32'h99)
            begin err_cnt++; $display("FAIL hz_drain got %0d/%0h exp 9/99", RFWA, RFWD); end
        tick();
        vec_cnt++; if (PendCount !== 3'd0) begin err_cnt++; $display("FAIL hz_empty got %0d exp 0", PendCount); end
        idle_in();
    endtask

    task automatic test_reset_mid();
        RegWriteW = 1; rdW = 23; ResultW = 32'h0;
        for (int i = 0; i < 3; i++) begin
            McValid = 1; McRd = 5'(13 + i); McResult = 32'hC0 + 32'(i); tick();
        end
        McValid = 0; #1;
        vec_cnt++; if (PendCount !== 3'd3) begin err_cnt++; $display("FAIL rm_pre got %0d exp 3", PendCount); end
        RegWriteW = 0; RESET = 1; QueryRs1 = 13; #1;
        vec_cnt++; if (RFWE !== 1'b0 || RFWA !== 5'd0 || RFWD !== 32'd0)
            begin err_cnt++; $display("FAIL rm_rf got %0h/%0d/%0h exp 0/0/0", RFWE, RFWA, RFWD); end
        vec_cnt++; if (PendCount !== 3'd0) begin err_cnt++; $display("FAIL rm_count got %0d exp 0", PendCount); end
        vec_cnt++; if (PendHit !== 3'b000 || McReady !== 1'b0 || BubbleReq !== 1'b0)
            begin err_cnt++; $display("FAIL rm_misc got %0b/%0h/%0h exp 000/0/0", PendHit, McReady, BubbleReq); end
        tick();
        RESET = 0; #1;
        vec_cnt++; if (PendCount !== 3'd0) begin err_cnt++; $display("FAIL rm_after got %0d exp 0", PendCount); end
        vec_cnt++; if (RFWE !== 1'b0 || PendHit !== 3'b000)
            begin err_cnt++; $display("FAIL rm_dropped got %0h/%0b exp 0/000", RFWE, PendHit); end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_w_only();
        test_w_then_idle();
        test_fill();
        test_simul();
        test_hazard();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
